// File: rtl/buffet_window_reader.sv
// Read-side buffet controller: walks a KH x KW stencil window along each buffered row,
// issues head-relative read indices, passes returned data through, and shrinks one row per output row.
module buffet_window_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 16,
  parameter int ROW_LEN    = 64,
  parameter int OUT_COLS   = 62,
  parameter int OUT_ROWS   = 62,
  parameter int KH         = 3,
  parameter int KW         = 3,
  parameter int MAX_OUT    = 4
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_WIDTH-1:0]  read_idx,
  output logic                  read_idx_valid,
  input  logic                  read_idx_ready,
  output logic                  read_will_update,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  read_data_valid,
  output logic                  read_data_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [IDX_WIDTH-1:0]  shrink_num,
  output logic                  shrink_valid,
  input  logic                  shrink_ready
);

  localparam int YW  = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam int XW  = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam int KYW = (KH > 1) ? $clog2(KH) : 1;
  localparam int KXW = (KW > 1) ? $clog2(KW) : 1;
  localparam int OW  = $clog2(MAX_OUT + 1);
  localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  localparam logic [YW-1:0]  Y_LAST  = YW'(OUT_ROWS - 1);
  localparam logic [XW-1:0]  X_LAST  = XW'(OUT_COLS - 1);
  localparam logic [KYW-1:0] KY_LAST = KYW'(KH - 1);
  localparam logic [KXW-1:0] KX_LAST = KXW'(KW - 1);
  localparam logic [PW-1:0]  P_LAST  = PW'(MAX_OUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, SHRINK, FIN} state_t;

  state_t           state_q, state_d;
  logic [YW-1:0]    y_q, y_d;
  logic [XW-1:0]    x_q, x_d;
  logic [KYW-1:0]   ky_q, ky_d;
  logic [KXW-1:0]   kx_q, kx_d;
  logic [OW-1:0]    outst_q, outst_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [MAX_OUT-1:0] tap_q, tap_d;

  logic idx_hs, data_hs, tap_last;

  // Data return is a pure pass-through; only the last-tap marker needs tracking.
  assign out_data         = read_data;
  assign out_valid        = read_data_valid;
  assign read_data_ready  = out_ready;
  assign read_will_update = 1'b0;

  assign read_idx = IDX_WIDTH'(ky_q) * IDX_WIDTH'(ROW_LEN) + IDX_WIDTH'(x_q) + IDX_WIDTH'(kx_q);
  assign shrink_num = shrink_valid ? IDX_WIDTH'(ROW_LEN) : '0;

  assign idx_hs   = read_idx_valid && read_idx_ready;
  // Returns arriving with nothing outstanding (e.g. after an abort) are passed but not popped.
  assign data_hs  = read_data_valid && out_ready && (outst_q != '0);
  assign tap_last = (ky_q == KY_LAST) && (kx_q == KX_LAST);
  assign out_last = (outst_q != '0) ? tap_q[rd_ptr_q] : 1'b0;

  generate
    for (genvar gi = 0; gi < MAX_OUT; gi++) begin : g_tap
      assign tap_d[gi] = (idx_hs && (wr_ptr_q == PW'(gi))) ? tap_last : tap_q[gi];
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    outst_d  = outst_q;
    if (idx_hs)  wr_ptr_d = (wr_ptr_q == P_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (data_hs) rd_ptr_d = (rd_ptr_q == P_LAST) ? '0 : rd_ptr_q + 1'b1;
    if (idx_hs && !data_hs)      outst_d = outst_q + 1'b1;
    else if (!idx_hs && data_hs) outst_d = outst_q - 1'b1;
  end

  always_comb begin
    state_d        = state_q;
    y_d            = y_q;
    x_d            = x_q;
    ky_d           = ky_q;
    kx_d           = kx_q;
    read_idx_valid = 1'b0;
    shrink_valid   = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    unique case (state_q)
      IDLE: begin
        y_d  = '0;
        x_d  = '0;
        ky_d = '0;
        kx_d = '0;
        if (start) state_d = ISSUE;
      end
      ISSUE: begin
        busy = 1'b1;
        // Gate on the registered count so a same-cycle return cannot re-open the window.
        read_idx_valid = (outst_q < OW'(MAX_OUT));
        if (read_idx_valid && read_idx_ready) begin
          if (kx_q != KX_LAST) begin
            kx_d = kx_q + 1'b1;
          end else begin
            kx_d = '0;
            if (ky_q != KY_LAST) begin
              ky_d = ky_q + 1'b1;
            end else begin
              ky_d = '0;
              if (x_q != X_LAST) begin
                x_d = x_q + 1'b1;
              end else begin
                x_d     = '0;
                state_d = DRAIN;
              end
            end
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (outst_q == '0) state_d = SHRINK;
      end
      SHRINK: begin
        busy         = 1'b1;
        shrink_valid = 1'b1;
        if (shrink_ready) begin
          if (y_q == Y_LAST) begin
            state_d = FIN;
          end else begin
            y_d     = y_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q  <= IDLE;
      y_q      <= '0;
      x_q      <= '0;
      ky_q     <= '0;
      kx_q     <= '0;
      outst_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tap_q    <= '0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      x_q      <= x_d;
      ky_q     <= ky_d;
      kx_q     <= kx_d;
      outst_q  <= outst_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tap_q    <= tap_d;
    end
  end

endmodule
